// File: rtl/phase_quantizer.sv
// phase_quantizer: forms delay-embedded pairs (x[n], x[n-TAU]) from the accepted sample
// stream, normalises each coordinate against the previous beat's min/max and quantises it
// to 0..L with two parallel restoring dividers. Define PHASE_QUANT_CLIP_CNT_EN to add the
// clip_cnt output, which reports how many emitted coordinates of the previous beat clamped.
module phase_quantizer #(
   parameter int DATA_WIDTH = 16,
   parameter int L          = 6,
   parameter int TAU        = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic                         x_valid,
   input  logic                         qrs_in,
   output logic                         x_ready,
   output logic        [DATA_WIDTH-1:0] vqx,
   output logic        [DATA_WIDTH-1:0] vqy,
   output logic                         q_valid,
   output logic                         qrs,
   output logic                         cv1_flag
`ifdef PHASE_QUANT_CLIP_CNT_EN
   ,
   output logic        [DATA_WIDTH-1:0] clip_cnt
`endif
);

   localparam int LW = $clog2(L + 1);
   localparam int NW = DATA_WIDTH + 1 + LW;
   localparam int IW = $clog2(NW);
   localparam int FW = $clog2(TAU + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

   state_t state_q, state_d;

   logic signed [DATA_WIDTH-1:0] dly_q [TAU];
   logic        [FW-1:0]         fill_q;
   logic signed [DATA_WIDTH-1:0] run_min_q, run_max_q, ref_min_q, ref_max_q;
   logic                         ref_valid_q;
   logic signed [DATA_WIDTH-1:0] sx_q, sy_q, smin_q, smax_q;
   logic                         sqrs_q;
   logic                         xlo_q, xhi_q, ylo_q, yhi_q;
   logic        [NW-1:0]         numx_q, numy_q, remx_q, remy_q;
   logic        [NW-1:0]         numx_d, numy_d, remx_d, remy_d;
   logic        [DATA_WIDTH:0]   den_q;
   logic        [IW-1:0]         it_q;
   logic        [DATA_WIDTH-1:0] vqx_q, vqy_q;
   logic                         qrs_q, cv1_q;
   logic        [1:0]            qcnt_q;

   logic                         accept, emit, lastIter;
   logic signed [DATA_WIDTH:0]   diffX, diffY;
   logic        [DATA_WIDTH:0]   denom;
   logic                         xloD, xhiD, yloD, yhiD;
   logic        [NW-1:0]         numXld, numYld;
   logic        [NW:0]           trialX, trialY, denExt;
   logic        [LW-1:0]         qx, qy;

   assign accept   = x_valid && x_ready;
   assign emit     = (ref_valid_q || qrs_in) && (fill_q == FW'(TAU));
   assign lastIter = (it_q == IW'(NW - 1));

   // State register; reset abandons any division in flight
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state; everything freezes while en is low, absorbed samples stay in IDLE
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            IDLE:    if (accept && emit) state_d = LOAD;
            LOAD:    state_d = DIV;
            DIV:     if (lastIter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from state
   always_comb begin
      x_ready = 1'b0;
      q_valid = 1'b0;
      if (en && !rst) begin
         x_ready = (state_q == IDLE);
         q_valid = (state_q == DONE);
      end
   end

   // Delay line, beat range trackers and capture of the pair with its reference range
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAU; i++) dly_q[i] <= '0;
         fill_q      <= '0;
         run_min_q   <= '0;
         run_max_q   <= '0;
         ref_min_q   <= '0;
         ref_max_q   <= '0;
         ref_valid_q <= 1'b0;
         sx_q        <= '0;
         sy_q        <= '0;
         smin_q      <= '0;
         smax_q      <= '0;
         sqrs_q      <= 1'b0;
      end else if (accept) begin
         dly_q[0] <= x;
         for (int i = 1; i < TAU; i++) dly_q[i] <= dly_q[i-1];
         if (fill_q != FW'(TAU)) fill_q <= fill_q + FW'(1);
         if (qrs_in) begin
            ref_min_q   <= run_min_q;
            ref_max_q   <= run_max_q;
            run_min_q   <= x;
            run_max_q   <= x;
            ref_valid_q <= 1'b1;
         end else begin
            if (x < run_min_q) run_min_q <= x;
            if (x > run_max_q) run_max_q <= x;
         end
         sx_q   <= x;
         sy_q   <= dly_q[TAU-1];
         smin_q <= qrs_in ? run_min_q : ref_min_q;
         smax_q <= qrs_in ? run_max_q : ref_max_q;
         sqrs_q <= qrs_in;
      end
   end

   // Clamp decisions, scaled numerators, shared denominator and one restoring step per coordinate
   always_comb begin
      diffX  = {sx_q[DATA_WIDTH-1], sx_q} - {smin_q[DATA_WIDTH-1], smin_q};
      diffY  = {sy_q[DATA_WIDTH-1], sy_q} - {smin_q[DATA_WIDTH-1], smin_q};
      denom  = {smax_q[DATA_WIDTH-1], smax_q} - {smin_q[DATA_WIDTH-1], smin_q}
               + (DATA_WIDTH + 1)'(1);
      xloD   = diffX[DATA_WIDTH];
      yloD   = diffY[DATA_WIDTH];
      xhiD   = sx_q > smax_q;
      yhiD   = sy_q > smax_q;
      numXld = NW'(diffX[DATA_WIDTH-1:0]) * NW'(L + 1);
      numYld = NW'(diffY[DATA_WIDTH-1:0]) * NW'(L + 1);
      denExt = (NW + 1)'(den_q);
      trialX = {remx_q, numx_q[NW-1]};
      trialY = {remy_q, numy_q[NW-1]};
      remx_d = remx_q;
      remy_d = remy_q;
      numx_d = numx_q;
      numy_d = numy_q;
      if (trialX >= denExt) begin
         remx_d = NW'(trialX - denExt);
         numx_d = {numx_q[NW-2:0], 1'b1};
      end else begin
         remx_d = trialX[NW-1:0];
         numx_d = {numx_q[NW-2:0], 1'b0};
      end
      if (trialY >= denExt) begin
         remy_d = NW'(trialY - denExt);
         numy_d = {numy_q[NW-2:0], 1'b1};
      end else begin
         remy_d = trialY[NW-1:0];
         numy_d = {numy_q[NW-2:0], 1'b0};
      end
      qx = xlo_q ? '0 : (xhi_q ? LW'(L) : numx_d[LW-1:0]);
      qy = ylo_q ? '0 : (yhi_q ? LW'(L) : numy_d[LW-1:0]);
   end

   // Divider sequencing, output registers and the reference-beat flag
   always_ff @(posedge clk) begin
      if (rst) begin
         xlo_q  <= 1'b0;
         xhi_q  <= 1'b0;
         ylo_q  <= 1'b0;
         yhi_q  <= 1'b0;
         numx_q <= '0;
         numy_q <= '0;
         remx_q <= '0;
         remy_q <= '0;
         den_q  <= '0;
         it_q   <= '0;
         vqx_q  <= '0;
         vqy_q  <= '0;
         qrs_q  <= 1'b0;
         cv1_q  <= 1'b1;
         qcnt_q <= '0;
      end else if (en) begin
         case (state_q)
            LOAD: begin
               xlo_q  <= xloD;
               xhi_q  <= !xloD && xhiD;
               ylo_q  <= yloD;
               yhi_q  <= !yloD && yhiD;
               numx_q <= (xloD || xhiD) ? '0 : numXld;
               numy_q <= (yloD || yhiD) ? '0 : numYld;
               remx_q <= '0;
               remy_q <= '0;
               den_q  <= denom;
               it_q   <= '0;
            end
            DIV: begin
               remx_q <= remx_d;
               remy_q <= remy_d;
               numx_q <= numx_d;
               numy_q <= numy_d;
               it_q   <= it_q + IW'(1);
               if (lastIter) begin
                  vqx_q <= DATA_WIDTH'(qx);
                  vqy_q <= DATA_WIDTH'(qy);
                  qrs_q <= sqrs_q;
               end
            end
            DONE: begin
               if (qrs_q) begin
                  if (qcnt_q != 2'd0) cv1_q <= 1'b0;
                  if (qcnt_q != 2'd3) qcnt_q <= qcnt_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign vqx      = vqx_q;
   assign vqy      = vqy_q;
   assign qrs      = qrs_q;
   assign cv1_flag = cv1_q;

`ifdef PHASE_QUANT_CLIP_CNT_EN
   logic [DATA_WIDTH-1:0] clipAcc_q, clip_q, nclamp;

   assign nclamp   = DATA_WIDTH'(xlo_q || xhi_q) + DATA_WIDTH'(ylo_q || yhi_q);
   assign clip_cnt = clip_q;

   // Per-beat clamp count, published alongside the qrs output that closes the beat
   always_ff @(posedge clk) begin
      if (rst) begin
         clipAcc_q <= '0;
         clip_q    <= '0;
      end else if (en && state_q == DIV && lastIter) begin
         if (sqrs_q) begin
            clip_q    <= clipAcc_q;
            clipAcc_q <= nclamp;
         end else begin
            clipAcc_q <= clipAcc_q + nclamp;
         end
      end
   end
`endif

endmodule

// File: tb/tb_phase_quantizer.sv
// tb_phase_quantizer: directed and randomized stimulus for phase_quantizer, checked against
// a behavioural model of beat ranges, embedding pairs and quantisation kept in the bench.
module tb_phase_quantizer;

   localparam int DW   = 16;
   localparam int LQ   = 6;
   localparam int TAUB = 4;
   localparam int NW   = DW + 1 + $clog2(LQ + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b1;
   logic signed [DW-1:0] x = '0;
   logic                 x_valid = 1'b0;
   logic                 qrs_in = 1'b0;
   logic                 x_ready;
   logic        [DW-1:0] vqx, vqy;
   logic                 q_valid, qrs, cv1_flag;
`ifdef PHASE_QUANT_CLIP_CNT_EN
   logic        [DW-1:0] clip_cnt;
`endif

   phase_quantizer #(.DATA_WIDTH(DW), .L(LQ), .TAU(TAUB)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .x_valid(x_valid), .qrs_in(qrs_in),
      .x_ready(x_ready), .vqx(vqx), .vqy(vqy), .q_valid(q_valid), .qrs(qrs),
      .cv1_flag(cv1_flag)
`ifdef PHASE_QUANT_CLIP_CNT_EN
      , .clip_cnt(clip_cnt)
`endif
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   int compareCount = 0;
   int mismatchCount = 0;
   int pauseAt = 0;
   int pauseLen = 0;

   // Behavioural model state
   int     hist[$];
   int     runMin, runMax, refMin, refMax;
   bit     refValid;
   int     qrsOuts;
   longint clipAcc, clipShown;

   int dirS [23] = '{-100, 99, 0, 0, 0, -100, 99, 0, 0, 0, 0, -100, 99, 0, 150, -500,
                     7, 7, 7, 7, 7, 7, 8};
   bit dirQ [23] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 1, 0};

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      compareCount++;
      if (actual != expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic void modelReset();
      hist.delete();
      runMin = 0; runMax = 0; refMin = 0; refMax = 0;
      refValid = 0; qrsOuts = 0; clipAcc = 0; clipShown = 0;
   endfunction

   function automatic int quant(input int s, input int mn, input int mx);
      if (s < mn) return 0;
      if (s > mx) return LQ;
      return int'(((longint'(s) - mn) * (LQ + 1)) / (longint'(mx) - mn + 1));
   endfunction

   function automatic int clamped(input int s, input int mn, input int mx);
      return (s < mn || s > mx) ? 1 : 0;
   endfunction

   function automatic void modelAccept(input int s, input bit q, output bit emit,
                                       output int ex, output int ey, output bit ecv1,
                                       output bit ecv1n, output longint eclip);
      int y;
      hist.push_back(s);
      if (q) begin
         refMin = runMin; refMax = runMax; refValid = 1;
         runMin = s; runMax = s;
      end else begin
         if (s < runMin) runMin = s;
         if (s > runMax) runMax = s;
      end
      emit = refValid && (hist.size() >= TAUB + 1);
      ex = 0; ey = 0; ecv1 = 0; ecv1n = 0; eclip = 0;
      if (emit) begin
         y     = hist[hist.size() - 1 - TAUB];
         ex    = quant(s, refMin, refMax);
         ey    = quant(y, refMin, refMax);
         ecv1  = (qrsOuts < 2);
         if (q) begin
            clipShown = clipAcc;
            clipAcc   = clamped(s, refMin, refMax) + clamped(y, refMin, refMax);
            qrsOuts++;
         end else begin
            clipAcc += clamped(s, refMin, refMax) + clamped(y, refMin, refMax);
         end
         ecv1n = (qrsOuts < 2);
         eclip = clipShown;
      end
      while (hist.size() > TAUB + 1) void'(hist.pop_front());
   endfunction

   task automatic applyReset();
      @(negedge clk);
      rst = 1; x_valid = 0; qrs_in = 0; en = 1;
      @(posedge clk); #1;
      checkOutput("rst_ready", x_ready, 0);
      checkOutput("rst_vqx", vqx, 0);
      checkOutput("rst_vqy", vqy, 0);
      checkOutput("rst_qvalid", q_valid, 0);
      checkOutput("rst_qrs", qrs, 0);
      checkOutput("rst_cv1", cv1_flag, 1);
`ifdef PHASE_QUANT_CLIP_CNT_EN
      checkOutput("rst_clip", clip_cnt, 0);
`endif
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      checkOutput("post_rst_ready", x_ready, 1);
      modelReset();
   endtask

   // Offers one sample, then follows it to either absorption or its emitted outputs
   task automatic applyStimulus(input int sample, input bit q);
      int guard, cnt, ex, ey;
      bit emit, ecv1, ecv1n;
      longint eclip;
      guard = 0;
      @(negedge clk);
      while (!x_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!x_ready) begin
         checkOutput("ready_timeout", 0, 1);
         return;
      end
      x = DW'(sample); x_valid = 1; qrs_in = q;
      @(posedge clk); #1;
      x_valid = 0; qrs_in = 0;
      modelAccept(sample, q, emit, ex, ey, ecv1, ecv1n, eclip);
      if (!emit) begin
         checkOutput("absorb_ready", x_ready, 1);
         checkOutput("absorb_qvalid", q_valid, 0);
      end else begin
         checkOutput("busy_ready", x_ready, 0);
         cnt = 1;
         while (!q_valid && cnt < NW + 60) begin
            if (pauseLen > 0 && cnt == pauseAt) en = 0;
            if (pauseLen > 0 && cnt == pauseAt + pauseLen) en = 1;
            @(posedge clk); #1;
            cnt++;
         end
         en = 1;
         checkOutput("latency", cnt, NW + 2 + pauseLen);
         checkOutput("vqx", vqx, ex);
         checkOutput("vqy", vqy, ey);
         checkOutput("qrs", qrs, q);
         checkOutput("cv1", cv1_flag, ecv1);
`ifdef PHASE_QUANT_CLIP_CNT_EN
         checkOutput("clip_cnt", clip_cnt, eclip);
`endif
         @(posedge clk); #1;
         checkOutput("qvalid_pulse", q_valid, 0);
         checkOutput("ready_after", x_ready, 1);
         checkOutput("cv1_after", cv1_flag, ecv1n);
         checkOutput("hold_vqx", vqx, ex);
         checkOutput("hold_vqy", vqy, ey);
      end
   endtask

   // Hard stop in case the design never releases the bench
   initial begin
      #500us;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed beats, enable stall, random traffic, reset mid-divide
   initial begin
      int seen, s;
      bit q;
      modelReset();
      applyReset();

      for (int i = 0; i < 23; i++) applyStimulus(dirS[i], dirQ[i]);

      @(negedge clk);
      en = 0;
      @(posedge clk); #1;
      checkOutput("en_low_ready", x_ready, 0);
      en = 1;

      pauseAt = 5; pauseLen = 4;
      applyStimulus(20, 0);
      pauseAt = 0; pauseLen = 0;

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) s = int'($urandom_range(0, 65535)) - 32768;
         else                           s = int'($urandom_range(0, 600)) - 300;
         q = ($urandom_range(0, 7) == 0);
         applyStimulus(s, q);
      end

      @(negedge clk);
      x = DW'(25); x_valid = 1; qrs_in = 1;
      @(posedge clk); #1;
      x_valid = 0; qrs_in = 0;
      checkOutput("abort_busy", x_ready, 0);
      repeat (11) @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
      checkOutput("abort_rst_ready", x_ready, 0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      repeat (NW + 6) begin
         @(posedge clk); #1;
         if (q_valid) seen++;
      end
      checkOutput("abort_no_qvalid", seen, 0);
      checkOutput("abort_cv1", cv1_flag, 1);
      checkOutput("abort_vqx", vqx, 0);
      modelReset();
      applyStimulus(-50, 0);
      applyStimulus(50, 0);
      applyStimulus(10, 0);
      applyStimulus(20, 0);
      applyStimulus(30, 0);
      applyStimulus(0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/phase_quantizer.md
# phase_quantizer

Upstream stage of the phase-space matrix / CV block. It takes the filtered ECG sample stream and forms delay-embedded pairs (x[n], x[n-TAU]). Each pair is normalised against the previous beat's min/max and quantised to L+1 levels. It emits the `vqx`/`vqy`/`qrs`/`cv1_flag` set the downstream block consumes, and `q_valid` drives that block's `en`. A multicycle divider sets the throughput, so the input side uses a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16: sample and output width.
- `L`, 6: highest quantisation level; outputs span 0..L.
- `TAU`, 4: embedding delay in accepted samples; legal range 1..15.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: block enable; when 0 the FSM holds and `x_ready`=0.
- `x`  in  DATA_WIDTH signed: input sample.
- `x_valid`  in  1: `x` is valid.
- `qrs_in`  in  1: the offered sample is the first sample of a new beat; sampled only on accept.
- `x_ready`  out  1: block can accept a sample.
- `vqx`  out  DATA_WIDTH: quantised x[n], zero-extended, range 0..L.
- `vqy`  out  DATA_WIDTH: quantised x[n-TAU], zero-extended, range 0..L.
- `q_valid`  out  1: one-cycle pulse; `vqx`/`vqy`/`qrs`/`cv1_flag` are valid.
- `qrs`  out  1: `qrs_in` of the quantised sample, aligned with `q_valid`.
- `cv1_flag`  out  1: level; the current output belongs to the reference (first quantised) beat.

## Operation
- Accept: `x_valid && x_ready && en`. Only accepted samples advance the delay line, the counters and the range trackers.
- Delay line: TAU-deep shift register. A fill counter saturates at TAU. A pair exists once TAU+1 samples have been accepted since reset.
- Range tracking: `run_min`/`run_max` track the current beat.
  - On accept with `qrs_in`=1: `ref_min`/`ref_max` <= `run_min`/`run_max` (excluding this sample), `run_min`/`run_max` <= `x`, and `ref_valid` <= 1.
  - Otherwise the running values update with `x`.
- Emission rule: the pair is quantised and emitted only when `ref_valid`=1 (including the one just set) and the pair exists. Otherwise the sample is absorbed, no `q_valid` is produced, and `x_ready` stays 1.
- Quantisation, per coordinate s:
  - s < `ref_min` gives 0; s > `ref_max` gives L.
  - Otherwise q = floor(((s-`ref_min`)·(L+1)) / (`ref_max`-`ref_min`+1)).
  - Denominator is never 0, and q ≤ L always holds.
- Arithmetic: differences use DATA_WIDTH+1 signed bits. Numerator width is NW = DATA_WIDTH+1+$clog2(L+1). Two parallel restoring dividers run, one per coordinate, each taking NW iterations.
- FSM: IDLE (`x_ready`=1) → LOAD (clamp decisions, numerators/denominator) → DIV (NW cycles) → DONE (`q_valid`=1 for one cycle) → IDLE. Non-emitting accepts stay in IDLE.
- `cv1_flag`: set to 1 by reset. A 2-bit saturating counter counts emitted `qrs`=1 outputs. `cv1_flag` clears on the cycle after the second such output, so that output still carries `cv1_flag`=1.
- `en`=0 mid-DIV: the state and the iteration count freeze and resume when `en` returns.
- `rst` mid-operation: the division aborts with no `q_valid`. Delay line, fill count, `ref_valid` and all range registers clear.

## Timing
- Reset values: `vqx`=0, `vqy`=0, `q_valid`=0, `qrs`=0, `cv1_flag`=1. `x_ready`=0 while `rst`=1 and 1 the cycle after.
- Latency: `q_valid` rises exactly NW+2 cycles after the accept edge. For the defaults (NW=20) this is 22 cycles.
- `x_ready` returns to 1 the cycle after `q_valid`. Maximum throughput is one emitting sample per NW+3 cycles.
- Outputs hold their values between `q_valid` pulses.

## Configuration
- `PHASE_QUANT_CLIP_CNT_EN` defined:
  - Adds output `clip_cnt` (DATA_WIDTH).
  - An internal counter increments once per emitted coordinate clamped to 0 or L; both coordinates clamped counts +2.
  - On an emitted `qrs`=1 output, `clip_cnt` latches the previous beat's count and the counter restarts, counting that output's clamps. Reset value 0.
- Undefined: no port and no counter logic.

## Test plan
- Reset, then 4 accepts without `qrs_in`, then a `qrs_in` accept → no `q_valid` until that fifth accept; it emits with `qrs`=1, `cv1_flag`=1, 22 cycles later.
- Beat 1 spans -100..99, then `qrs_in`; next samples 0, -100, 99 with x[n-TAU]=0 → `vqx`=3, 0, 6 respectively; `vqy`=3.
- With the same range, samples 150 and -500 → `vqx`=6 and 0. With the macro, the next `qrs` output shows `clip_cnt`=2.
- Flat beat (all samples 7), then `x`=7 → denominator 1, `vqx`=0; `x`=8 → `vqx`=6.
- Second emitted `qrs` output → `cv1_flag`=1 on it, 0 from the next cycle; the third `qrs` output shows `cv1_flag`=0.
- Assert `rst` 10 cycles into DIV → no `q_valid`. The next 5 samples are absorbed (`ref_valid`=0) until a new `qrs_in` arrives.
